// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4-to-1 mux select through i0..i3, waits
// SETTLE_CYCLES per input, samples mux_o and reports the 4-bit word.
// Ports: clk, rst (sync, active-high), start, mux_o -> s1, s0, busy, done,
//        data_out[3:0]. Optional `MUX_SCAN_CHECK_EN adds expected/mismatch.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_o,
`ifdef MUX_SCAN_CHECK_EN
    input  logic [3:0] expected,
    output logic       mismatch,
`endif
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       done,
    output logic [3:0] data_out
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end
    if (((SETTLE_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("CNT_W too narrow for SETTLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       acc_q, acc_d;
    logic [3:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    acc_d   = 4'd0;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                acc_d[idx_q] = mux_o;
                cnt_d        = '0;
                if (idx_q == 2'd3) begin
                    // Publish on DONE entry so data_out is valid with done
                    // and never exposes a partial word.
                    state_d = DONE;
                    data_d  = acc_d;
                    idx_d   = 2'd0;
                end else begin
                    state_d = SETTLE;
                    idx_d   = idx_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            acc_q   <= 4'd0;
            data_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // idx is a register and is parked at 0 outside a scan, so the select
    // lines come straight from it.
    assign s1       = idx_q[1];
    assign s0       = idx_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;

`ifdef MUX_SCAN_CHECK_EN
    logic mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == DONE) begin
            mismatch_d = (acc_q != expected);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule
